// File: rtl/data_mem_ctrl.sv
// Handshaked byte-addressable data memory for the RV32I datapath.
// Loads/stores with wait states, fault detection and an internal write-back select.
module data_mem_ctrl #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data,
    input  logic [2:0]  funct3,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_to_reg,
    output logic        busy,
    output logic        ready,
    output logic        err,
    output logic [31:0] data_out
);
    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_reg;
    logic [2:0]  wait_cnt_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [2:0]  funct3_reg;
    logic        read_reg;
    logic        write_reg;
    logic        to_reg_reg;

    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [2:0]  op_funct3;
    logic        op_read;
    logic        op_write;
    logic        op_to_reg;

    // With no wait states the accept edge is also the RESP edge, so the
    // operation is taken from the live inputs while still in IDLE.
    always_comb begin
        if (state_reg == IDLE) begin
            op_addr   = alu_result;
            op_wdata  = write_data;
            op_funct3 = funct3;
            op_read   = mem_read;
            op_write  = mem_write;
            op_to_reg = mem_to_reg;
        end else begin
            op_addr   = addr_reg;
            op_wdata  = wdata_reg;
            op_funct3 = funct3_reg;
            op_read   = read_reg;
            op_write  = write_reg;
            op_to_reg = to_reg_reg;
        end
    end

    logic             enter_resp;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       lane;

    assign enter_resp = ((state_reg == IDLE) && req && (WAIT_STATES == 0)) ||
                        ((state_reg == WAIT) && (wait_cnt_reg == 3'd1));
    assign word_idx   = op_addr[ADDR_WIDTH-1:2];
    assign lane       = op_addr[1:0];

    logic fault;
    always_comb begin
        fault = 1'b0;
        if (op_read && op_write)
            fault = 1'b1;
        else if (op_read)
            fault = (op_funct3 == 3'd3) || (op_funct3[2:1] == 2'b11);
        else if (op_write)
            fault = (op_funct3 > 3'd2);
        if (op_read || op_write) begin
            if ((op_funct3[1:0] == 2'b01) && lane[0])
                fault = 1'b1;
            if ((op_funct3 == 3'd2) && (lane != 2'b00))
                fault = 1'b1;
        end
    end

    logic [3:0]  lane_we;
    logic [31:0] lane_wdata;
    always_comb begin
        lane_we    = 4'b0000;
        lane_wdata = op_wdata;
        case (op_funct3)
            3'd0: begin
                lane_we    = 4'b0001 << lane;
                lane_wdata = {4{op_wdata[7:0]}};
            end
            3'd1: begin
                lane_we    = lane[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{op_wdata[15:0]}};
            end
            default: lane_we = 4'b1111;
        endcase
        if (!(enter_resp && op_write && !fault && !reset))
            lane_we = 4'b0000;
    end

    // One byte-wide array per lane; the read is combinational so the load
    // value is available on the same edge that enters RESP.
    logic [31:0] rd_word;
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            always_ff @(posedge sysclk) begin
                if (lane_we[gi])
                    lane_mem[word_idx] <= lane_wdata[gi*8 +: 8];
            end
            assign rd_word[gi*8 +: 8] = lane_mem[word_idx];
        end
    endgenerate

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_val;
    logic [31:0] resp_data;
    always_comb begin
        sel_byte = 8'(rd_word >> {lane, 3'b000});
        sel_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (op_funct3)
            3'd0:    load_val = {{24{sel_byte[7]}}, sel_byte};
            3'd4:    load_val = {24'd0, sel_byte};
            3'd1:    load_val = {{16{sel_half[15]}}, sel_half};
            3'd5:    load_val = {16'd0, sel_half};
            default: load_val = rd_word;
        endcase
        if (fault)
            resp_data = 32'd0;
        else if (op_read && op_to_reg)
            resp_data = load_val;
        else
            resp_data = op_addr;
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 3'd0;
            busy         <= 1'b0;
            ready        <= 1'b0;
            err          <= 1'b0;
            data_out     <= 32'd0;
            addr_reg     <= 32'd0;
            wdata_reg    <= 32'd0;
            funct3_reg   <= 3'd0;
            read_reg     <= 1'b0;
            write_reg    <= 1'b0;
            to_reg_reg   <= 1'b0;
        end else begin
            if (enter_resp) begin
                ready    <= 1'b1;
                err      <= fault;
                data_out <= resp_data;
            end
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        addr_reg   <= alu_result;
                        wdata_reg  <= write_data;
                        funct3_reg <= funct3;
                        read_reg   <= mem_read;
                        write_reg  <= mem_write;
                        to_reg_reg <= mem_to_reg;
                        busy       <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            state_reg <= RESP;
                        end else begin
                            state_reg    <= WAIT;
                            wait_cnt_reg <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt_reg == 3'd1) begin
                        state_reg    <= RESP;
                        wait_cnt_reg <= 3'd0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 3'd1;
                    end
                end
                RESP: begin
                    ready     <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised, handshaked data memory for the RISC-V datapath. Replaces the single-cycle word memory with a byte-addressable store that has configurable depth and wait states. It supports RV32I load/store widths (LB/LH/LW/LBU/LHU, SB/SH/SW) and detects misaligned or illegal accesses. It sits between the ALU result and the register-file write-back mux, and keeps the `mem_to_reg` selection internal.

## Interface
- `ADDR_WIDTH`, 10: byte-address bits used. Depth = 2^(ADDR_WIDTH-2) 32-bit words. Range 4..16.
- `WAIT_STATES`, 1: extra cycles between request accept and response. Range 0..7.
- `sysclk`  in  1: clock. All state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req`  in  1: request strobe. Sampled only in IDLE.
- `alu_result`  in  32: byte address for memory ops, and pass-through value when `mem_to_reg`=0.
- `write_data`  in  32: store data. Low byte/half used for SB/SH.
- `funct3`  in  3: access width/sign. 0 B, 1 H, 2 W, 4 BU, 5 HU.
- `mem_read`  in  1: load request.
- `mem_write`  in  1: store request.
- `mem_to_reg`  in  1: 1 selects load data for `data_out`, 0 selects `alu_result`.
- `busy`  out  1: request accepted, response not yet given.
- `ready`  out  1: one-cycle response pulse. `data_out` and `err` are valid with it.
- `err`  out  1: response was a fault (misaligned/illegal). Valid with `ready`.
- `data_out`  out  32: registered write-back value. Held until the next response.

## Operation
- FSM states are IDLE, WAIT and RESP.
  - IDLE → WAIT on `req`=1 at a rising edge when WAIT_STATES>0. IDLE → RESP directly when WAIT_STATES=0.
  - WAIT lasts exactly WAIT_STATES cycles (down-counter), then → RESP.
  - RESP lasts 1 cycle (`ready`=1), then → IDLE.
- Accept edge: `alu_result`, `write_data`, `funct3`, `mem_read`, `mem_write` and `mem_to_reg` are registered. Inputs may change freely afterwards.
- `req` while not IDLE is ignored. There is no queueing.
- A request with `req`=1 and both `mem_read` and `mem_write` = 0 is a pass-through. No memory access; the response carries `data_out` = captured `alu_result`.
- Word index = addr[ADDR_WIDTH-1:2]. Address bits above ADDR_WIDTH-1 are ignored, so addresses wrap modulo 2^ADDR_WIDTH. Byte lanes are little-endian.
- Fault conditions. A fault performs no memory update, `err`=1 at RESP, and `data_out`=0.
  - `mem_read` and `mem_write` both 1.
  - `funct3` ∈ {3,6,7} for a load.
  - `funct3` ∉ {0,1,2} for a store.
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠0.
- Loads:
  - B sign-extends lane addr[1:0]; BU zero-extends it.
  - H sign-extends half addr[1]; HU zero-extends it.
  - W returns the full word.
  - `data_out` = `mem_to_reg`_q ? load value : `alu_result`_q.
- Stores:
  - SB writes only byte lane addr[1:0] with `write_data`[7:0].
  - SH writes lanes {addr[1],0}/{addr[1],1} with `write_data`[15:0].
  - SW writes all 4 lanes.
  - Other lanes are unchanged.
  - `data_out` = `alu_result`_q.
- Memory contents power up to zero and are not cleared by `reset`.

## Timing
- Reset values: state IDLE, `busy`=0, `ready`=0, `err`=0, `data_out`=0, wait counter 0.
- Latency: `ready` is high in cycle WAIT_STATES+1 after the accept edge. Back-to-back throughput is one request per WAIT_STATES+2 cycles.
- `busy`=1 from the cycle after the accept edge through the RESP cycle inclusive.
- Store commit and load capture both occur on the edge that enters RESP. `data_out`/`err` update on that same edge.
- A load from the address written by the immediately preceding store returns the new data.
- `reset` asserted in WAIT has the following effect:
  - The request is aborted, memory is unchanged, and no `ready` is produced.
  - Outputs return to reset values asynchronously.
- `reset` asserted in RESP drops `ready` immediately. A store already committed stays committed.
- `req` held high continuously is re-accepted in the first IDLE cycle after RESP.

## Test plan
- **Reset.** Assert `reset` mid-WAIT of an SW (0x40 ← 0xDEADBEEF), then LW 0x40 → `data_out`=0x00000000. All outputs are 0 during reset.
- **Word round-trip, WAIT_STATES=1.** SW 0x04 ← 0xA5A5A5A5, then LW 0x04 with `mem_to_reg`=1 → `ready` 2 cycles after accept, `data_out`=0xA5A5A5A5, `err`=0.
- **Byte/half lanes.**
  - Store: SW 0x08 ← 0x00C0FFEE, SB 0x0B ← 0x80, SH 0x08 ← 0x1234.
  - LW 0x08 → 0x80C01234.
  - LB 0x0B → 0xFFFFFF80; LBU 0x0B → 0x00000080; LH 0x0A → 0xFFFF80C0.
- **Faults.**
  - LW 0x06 → `err`=1, `data_out`=0.
  - SH 0x09 → `err`=1, and a following LW 0x08 is unchanged.
  - `funct3`=3 load → `err`=1.
  - `mem_read`=`mem_write`=1 → `err`=1.
- **Pass-through and wrap, ADDR_WIDTH=10.** `mem_to_reg`=0 with `alu_result`=0x12345678 → `data_out`=0x12345678. SW 0x404 ← 0x11 then LW 0x004 → 0x00000011.
- **Handshake.** WAIT_STATES=0 and 7: `ready` at cycles 1 and 8 respectively. `req` pulses while `busy` are ignored. `req` held high yields responses every WAIT_STATES+2 cycles.
